hazard_stall_ctrl: RTL and testbench

- Pipeline stall/flush controller for the RV32IMA 5-stage core.
- Detects RAW hazards between the ID-stage consumer and EX/MEM producers, including branches and JALR resolved in ID.
- Sequences bounded 1- or 2-cycle stalls through a small FSM and drives PC/IF-ID enables, the ID/EX bubble and the IF/ID flush.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_stall_ctrl_if.sv | 40 ++++
 rtl/hazard_detect.sv | 47 ++++
 rtl/hazard_stall_ctrl.sv | 107 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard stall/flush controller.
package hazard_pkg;

   localparam int unsigned REG_ADDR_W_DEF = 5;
   localparam int unsigned PERF_CNT_W_DEF = 32;
   localparam int unsigned STALL_CNT_W    = 2;

   // branch_id encoding; 2'b11 is reserved and decoded as BR_NONE
   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_COND = 2'b01,
      BR_JALR = 2'b10
   } branch_e;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      STALL2   = 2'b01,
      DIV_WAIT = 2'b10
   } state_e;

   typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

   localparam stall_cnt_t STALL_N0 = 2'd0;
   localparam stall_cnt_t STALL_N1 = 2'd1;
   localparam stall_cnt_t STALL_N2 = 2'd2;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ID/EX/MEM hazard inputs and stall/flush outputs of the stall controller.
interface hazard_stall_ctrl_if #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned PERF_CNT_W = 32
);
   logic [REG_ADDR_W-1:0] rs1_id;
   logic [REG_ADDR_W-1:0] rs2_id;
   logic                  rs1_used_id;
   logic                  rs2_used_id;
   logic [1:0]            branch_id;
   logic [REG_ADDR_W-1:0] rd_ex;
   logic                  reg_write_ex;
   logic                  mem_read_ex;
   logic [REG_ADDR_W-1:0] rd_mem;
   logic                  mem_read_mem;
   logic                  branch_taken_id;
   logic                  div_busy_ex;
   logic                  stall;
   logic                  pc_en;
   logic                  if_id_en;
   logic                  id_ex_flush;
   logic                  if_id_flush;
   logic [PERF_CNT_W-1:0] stall_cycles;

   // pipeline side
   modport master (
      output rs1_id, rs2_id, rs1_used_id, rs2_used_id, branch_id,
             rd_ex, reg_write_ex, mem_read_ex, rd_mem, mem_read_mem,
             branch_taken_id, div_busy_ex,
      input  stall, pc_en, if_id_en, id_ex_flush, if_id_flush, stall_cycles
   );

   // controller side
   modport slave (
      input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, branch_id,
             rd_ex, reg_write_ex, mem_read_ex, rd_mem, mem_read_mem,
             branch_taken_id, div_busy_ex,
      output stall, pc_en, if_id_en, id_ex_flush, if_id_flush, stall_cycles
   );
endinterface

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detection: required stall cycles for the ID instruction.
module hazard_detect
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  rs1_used_id,
   input  logic                  rs2_used_id,
   input  logic [1:0]            branch_id,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic                  reg_write_ex,
   input  logic                  mem_read_ex,
   input  logic [REG_ADDR_W-1:0] rd_mem,
   input  logic                  mem_read_mem,
   output stall_cnt_t            n_c
);

   logic is_branch;
   logic use_rs2;
   logic match_ex;
   logic match_mem;

   always_comb begin
      is_branch = (branch_id == BR_COND) || (branch_id == BR_JALR);
      // JALR only reads rs1 in ID
      use_rs2   = rs2_used_id && (branch_id != BR_JALR);
      match_ex  = (rd_ex != '0) &&
                  ((rs1_used_id && (rs1_id == rd_ex)) || (use_rs2 && (rs2_id == rd_ex)));
      match_mem = (rd_mem != '0) &&
                  ((rs1_used_id && (rs1_id == rd_mem)) || (use_rs2 && (rs2_id == rd_mem)));

      n_c = STALL_N0;
      if (mem_read_mem && is_branch && match_mem) begin
         n_c = STALL_N1;
      end
      if (reg_write_ex && !mem_read_ex && is_branch && match_ex) begin
         n_c = STALL_N1;
      end
      // load-use dominates: the branch needs the loaded value in ID, two cycles away
      if (mem_read_ex && match_ex) begin
         n_c = is_branch ? STALL_N2 : STALL_N1;
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller with saturating stall-cycle counter.
// Optional MULDIV_STALL_EN: stall while the divider in EX is busy (DIV_WAIT).
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int unsigned PERF_CNT_W = PERF_CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   hazard_stall_ctrl_if.slave bus
);

   state_e                state_q;
   state_e                state_d;
   logic [PERF_CNT_W-1:0] stall_cycles_q;
   logic [PERF_CNT_W-1:0] stall_cycles_d;
   stall_cnt_t            n_c;
   logic                  stall_c;
   logic                  stall_out_c;
   logic                  div_busy_c;

   hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_detect (
      .rs1_id       (bus.rs1_id),
      .rs2_id       (bus.rs2_id),
      .rs1_used_id  (bus.rs1_used_id),
      .rs2_used_id  (bus.rs2_used_id),
      .branch_id    (bus.branch_id),
      .rd_ex        (bus.rd_ex),
      .reg_write_ex (bus.reg_write_ex),
      .mem_read_ex  (bus.mem_read_ex),
      .rd_mem       (bus.rd_mem),
      .mem_read_mem (bus.mem_read_mem),
      .n_c          (n_c)
   );

`ifdef MULDIV_STALL_EN
   assign div_busy_c = bus.div_busy_ex;
`else
   logic unused_div_busy;
   assign unused_div_busy = bus.div_busy_ex;
   assign div_busy_c      = 1'b0;
`endif

   // state register and stall counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   // next state and raw stall request
   always_comb begin
      state_d = state_q;
      stall_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (div_busy_c) begin
               stall_c = 1'b1;
               state_d = DIV_WAIT;
            end else begin
               stall_c = (n_c != STALL_N0);
               state_d = (n_c == STALL_N2) ? STALL2 : IDLE;
            end
         end
         STALL2: begin
            stall_c = 1'b1;
            state_d = IDLE;
         end
         DIV_WAIT: begin
            // exit cycle behaves exactly like IDLE without the divider term
            if (div_busy_c) begin
               stall_c = 1'b1;
            end else begin
               stall_c = (n_c != STALL_N0);
               state_d = (n_c == STALL_N2) ? STALL2 : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // outputs are held in their run state while reset is low
   always_comb begin
      stall_out_c    = reset && stall_c;
      stall_cycles_d = stall_cycles_q;
      if (stall_out_c && !(&stall_cycles_q)) begin
         stall_cycles_d = stall_cycles_q + PERF_CNT_W'(1);
      end
   end

   assign bus.stall        = stall_out_c;
   assign bus.pc_en        = !stall_out_c;
   assign bus.if_id_en     = !stall_out_c;
   assign bus.id_ex_flush  = stall_out_c;
   assign bus.if_id_flush  = reset && bus.branch_taken_id && !stall_out_c;
   assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; expectations follow MULDIV_STALL_EN when defined.
module tb_hazard_stall_ctrl;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   hazard_stall_ctrl_if #(.REG_ADDR_W(5), .PERF_CNT_W(32)) bus ();

   hazard_stall_ctrl #(
      .REG_ADDR_W (5),
      .PERF_CNT_W (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      bus.rs1_id          = '0;
      bus.rs2_id          = '0;
      bus.rs1_used_id     = 1'b0;
      bus.rs2_used_id     = 1'b0;
      bus.branch_id       = 2'b00;
      bus.rd_ex           = '0;
      bus.reg_write_ex    = 1'b0;
      bus.mem_read_ex     = 1'b0;
      bus.rd_mem          = '0;
      bus.mem_read_mem    = 1'b0;
      bus.branch_taken_id = 1'b0;
      bus.div_busy_ex     = 1'b0;
   endtask

   // inputs change just after the falling edge; outputs sampled 1 time unit later
   task automatic step();
      @(negedge clk);
      clr();
   endtask

   task automatic load_branch_55();
      bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd5;
      bus.rs1_id = 5'd5; bus.rs2_id = 5'd5;
      bus.rs1_used_id = 1'b1; bus.rs2_used_id = 1'b1;
      bus.branch_id = 2'b01;
   endtask

   int exp_cnt;
   logic exp_div;

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      clr();
`ifdef MULDIV_STALL_EN
      exp_div = 1'b1;
`else
      exp_div = 1'b0;
`endif

      // reset: outputs forced even with a hazard and taken branch present
      @(negedge clk);
      @(negedge clk);
      load_branch_55();
      bus.branch_taken_id = 1'b1;
      #1;
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_pc_en", 32'(bus.pc_en), 32'd1);
      chk("rst_if_id_en", 32'(bus.if_id_en), 32'd1);
      chk("rst_id_ex_flush", 32'(bus.id_ex_flush), 32'd0);
      chk("rst_if_id_flush", 32'(bus.if_id_flush), 32'd0);
      chk("rst_cnt", bus.stall_cycles, 32'd0);

      // lw x5 in EX, add x7,x5,x1 in ID: one-cycle load-use stall
      step();
      reset = 1'b1;
      bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd5;
      bus.rs1_id = 5'd5; bus.rs2_id = 5'd1;
      bus.rs1_used_id = 1'b1; bus.rs2_used_id = 1'b1;
      #1;
      chk("lu_stall", 32'(bus.stall), 32'd1);
      chk("lu_flush", 32'(bus.id_ex_flush), 32'd1);
      chk("lu_pc_en", 32'(bus.pc_en), 32'd0);
      chk("lu_if_id_en", 32'(bus.if_id_en), 32'd0);
      step();
      bus.mem_read_mem = 1'b1; bus.rd_mem = 5'd5;
      bus.rs1_id = 5'd5; bus.rs2_id = 5'd1;
      bus.rs1_used_id = 1'b1; bus.rs2_used_id = 1'b1;
      #1;
      chk("lu_release_stall", 32'(bus.stall), 32'd0);
      chk("lu_release_pc_en", 32'(bus.pc_en), 32'd1);
      chk("lu_cnt", bus.stall_cycles, 32'd1);

      // lw x5 in EX, beq x5,x5 in ID: exactly two stall cycles
      step();
      load_branch_55();
      #1;
      chk("lb_stall1", 32'(bus.stall), 32'd1);
      step();
      bus.branch_taken_id = 1'b1;
      #1;
      chk("lb_stall2", 32'(bus.stall), 32'd1);
      chk("lb_no_flush_stalled", 32'(bus.if_id_flush), 32'd0);
      chk("lb_cnt_mid", bus.stall_cycles, 32'd2);
      step();
      bus.branch_taken_id = 1'b1;
      #1;
      chk("lb_stall3", 32'(bus.stall), 32'd0);
      chk("lb_flush_taken", 32'(bus.if_id_flush), 32'd1);
      chk("lb_cnt", bus.stall_cycles, 32'd3);

      // add x6 in EX, beq x6,x2 in ID: one cycle
      step();
      bus.reg_write_ex = 1'b1; bus.rd_ex = 5'd6;
      bus.rs1_id = 5'd6; bus.rs2_id = 5'd2;
      bus.rs1_used_id = 1'b1; bus.rs2_used_id = 1'b1;
      bus.branch_id = 2'b01;
      #1;
      chk("ab_stall", 32'(bus.stall), 32'd1);
      step();
      #1;
      chk("ab_stall_after", 32'(bus.stall), 32'd0);
      chk("ab_cnt", bus.stall_cycles, 32'd4);

      // same with x0 as destination: never a hazard
      step();
      bus.reg_write_ex = 1'b1; bus.rd_ex = 5'd0;
      bus.rs1_id = 5'd0; bus.rs2_id = 5'd2;
      bus.rs1_used_id = 1'b1; bus.rs2_used_id = 1'b1;
      bus.branch_id = 2'b01;
      #1;
      chk("x0_stall", 32'(bus.stall), 32'd0);

      // ALU result to non-branch consumer is forwarded
      step();
      bus.reg_write_ex = 1'b1; bus.rd_ex = 5'd6;
      bus.rs1_id = 5'd6; bus.rs1_used_id = 1'b1;
      #1;
      chk("alu_fwd_stall", 32'(bus.stall), 32'd0);

      // load in MEM, JALR in ID reading only rs1; rs2 field aliases rd_mem
      step();
      bus.mem_read_mem = 1'b1; bus.rd_mem = 5'd9;
      bus.rs1_id = 5'd3; bus.rs2_id = 5'd9;
      bus.rs1_used_id = 1'b1; bus.rs2_used_id = 1'b1;
      bus.branch_id = 2'b10;
      #1;
      chk("jalr_rs2_ignored", 32'(bus.stall), 32'd0);

      // same operands on a conditional branch: one cycle
      step();
      bus.mem_read_mem = 1'b1; bus.rd_mem = 5'd9;
      bus.rs1_id = 5'd3; bus.rs2_id = 5'd9;
      bus.rs1_used_id = 1'b1; bus.rs2_used_id = 1'b1;
      bus.branch_id = 2'b01;
      #1;
      chk("mem_br_stall", 32'(bus.stall), 32'd1);

      // reserved branch encoding behaves as no branch
      step();
      bus.mem_read_mem = 1'b1; bus.rd_mem = 5'd9;
      bus.rs1_id = 5'd9; bus.rs1_used_id = 1'b1;
      bus.branch_id = 2'b11;
      #1;
      chk("br11_stall", 32'(bus.stall), 32'd0);
      chk("br11_cnt", bus.stall_cycles, 32'd5);

      // unused source never matches
      step();
      bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd4;
      bus.rs1_id = 5'd4; bus.rs1_used_id = 1'b0;
      #1;
      chk("unused_src_stall", 32'(bus.stall), 32'd0);

      // reset during STALL2 aborts the stall and clears the counter
      step();
      load_branch_55();
      #1;
      chk("rs2_stall1", 32'(bus.stall), 32'd1);
      step();
      reset = 1'b0;
      #1;
      chk("rs2_forced_stall", 32'(bus.stall), 32'd0);
      chk("rs2_forced_pc_en", 32'(bus.pc_en), 32'd1);
      step();
      reset = 1'b1;
      #1;
      chk("rs2_after_stall", 32'(bus.stall), 32'd0);
      chk("rs2_after_pc_en", 32'(bus.pc_en), 32'd1);
      chk("rs2_after_cnt", bus.stall_cycles, 32'd0);

      // divider busy for 10 cycles
      for (int i = 0; i < 10; i++) begin
         step();
         bus.div_busy_ex = 1'b1;
         #1;
         chk($sformatf("div_stall_%0d", i), 32'(bus.stall), 32'(exp_div));
      end
      step();
      #1;
      chk("div_release_stall", 32'(bus.stall), 32'd0);
      exp_cnt = exp_div ? 10 : 0;
      chk("div_cnt", bus.stall_cycles, 32'(exp_cnt));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
